mod8_cascade_display: RTL and testbench
=======================================

Name: mod8_cascade_display

Overview:
- Downstream consumer of the 4-bit mod-8 counter outputs Q[3:0] and Qcc_n, clocked by the same CP.
- Extends the count to two octal digits: a high-digit counter advances on each low-counter wrap event signalled by Qcc_n.
- Time-multiplexes both digits onto a two-digit active-low seven-segment display.
- Also exposes the 6-bit combined count and a sticky overflow flag.

Parameters:
- SCAN_DIV, 4, CP cycles per displayed digit before the scan toggles; legal range is 2 or more.

Ports:
- CP  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- M  input  1  count direction of the upstream counter: 1 = up, 0 = down.
- Q  input  4  low-digit value from the upstream counter; legal values 0-7.
- Qcc_n  input  1  active-low wrap/carry from the upstream counter; synchronous to CP.
- hi_digit  output  3  high-digit count, 0-7.
- total  output  6  combined count {hi_digit, Q[2:0]}; combinational from registers and input.
- ovf  output  1  sticky overflow/underflow flag.
- an_n  output  2  active-low digit enables: bit0 = low digit, bit1 = high digit.
- seg_n  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.

Behaviour:
- Clock and reset: one clock, CP. reset is asynchronous and active-high.
- Reset values: hi_digit=0, ovf=0, an_n=2'b11, seg_n=7'h7F, internal qcc_prev=1, scan counter=0, digit select sel=0.
- Reset priority: reset overrides every other event, including a wrap event in the same cycle.
- Wrap event detection:
  - qcc_prev <= Qcc_n every cycle.
  - A wrap event is qcc_prev==1 && Qcc_n==0, i.e. a falling transition between consecutive samples.
  - Qcc_n held low for several cycles counts as exactly one event.
  - The new hi_digit value is visible 1 cycle after the cycle in which Qcc_n is first sampled low.
- High-digit update on a wrap event:
  - M=1: hi_digit increments mod 8. On the 7->0 transition, ovf is set.
  - M=0: hi_digit decrements mod 8. On the 0->7 transition, ovf is set.
  - M is sampled in the same cycle as the event.
- ovf is cleared only by reset.
- total is {hi_digit, Q[2:0]} with no registering. It is meaningless while Q is greater than 7.
- Scan:
  - The scan counter runs 0..SCAN_DIV-1 and wraps.
  - When it wraps, sel toggles.
  - Each digit is therefore shown for SCAN_DIV cycles.
- Display registers, updated every cycle with 1-cycle latency:
  - an_n <= sel ? 2'b01 : 2'b10.
  - seg_n <= decode(sel ? {1'b0, hi_digit} : Q).
  - The first edge after reset release gives an_n=2'b10 and seg_n=decode(Q).
- Decode table for seg_n:
  - 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30.
  - 4 = 7'h19, 5 = 7'h12, 6 = 7'h02, 7 = 7'h78.
  - Any value 8-15 shows a dash = 7'h3F.
- Reset asserted mid-scan: the outputs immediately return to their reset values. The scan restarts at the low digit.

Optional Feature:
- Macro: MOD8_DISPLAY_DIR_EN.
- When defined, the port list adds an output dp_n (1 bit), the active-low decimal point.
  - dp_n is registered together with seg_n.
  - dp_n = ~M while the low digit is selected; dp_n = 1 while the high digit is selected.
  - dp_n resets to 1.
- When not defined, the port dp_n is absent and there is no direction indication.

Test Plan:
- Reset release with Q=3 and SCAN_DIV=4: first edge gives an_n=2'b10, seg_n=7'h30. After 4 cycles an_n=2'b01 and seg_n=7'h40 (hi_digit 0).
- M=1, eight 1-cycle low pulses on Qcc_n: hi_digit steps 1..7 then returns to 0. ovf goes to 1 on the eighth pulse, and total = {3'd0, Q[2:0]}.
- M=0 from reset, one Qcc_n low pulse: hi_digit=7, ovf=1, high-digit seg_n=7'h78.
- Qcc_n held low for 5 cycles, M=1: hi_digit increments by exactly 1.
- Assert reset asynchronously mid-cycle while hi_digit=5 and ovf=1: hi_digit, ovf, an_n and seg_n immediately become 0, 0, 2'b11 and 7'h7F. A wrap event coinciding with reset is ignored.
- Q=4'd9 with the low digit selected: seg_n=7'h3F. With MOD8_DISPLAY_DIR_EN defined and M=0 on the low digit: dp_n=1 (M=1 gives 0).

Source files
------------

// File: rtl/mod8_cascade_display.sv
// Two-digit octal cascade on an upstream mod-8 counter, multiplexed onto an active-low 7-seg display.
// Define MOD8_DISPLAY_DIR_EN to add the dp_n count-direction indicator on the low digit.
module mod8_cascade_display #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic       CP,
  input  logic       reset,
  input  logic       M,
  input  logic [3:0] Q,
  input  logic       Qcc_n,
  output logic [2:0] hi_digit,
  output logic [5:0] total,
  output logic       ovf,
  output logic [1:0] an_n,
  output logic [6:0] seg_n
`ifdef MOD8_DISPLAY_DIR_EN
  ,
  output logic       dp_n
`endif
);

  localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic             qcc_prev;
  logic             sel;
  logic [CNT_W-1:0] scan_cnt;
  logic             wrap;

  // Active-low {g,f,e,d,c,b,a}; anything beyond 7 renders as a dash
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // A held-low carry only counts once: react to the falling transition
  assign wrap  = qcc_prev & ~Qcc_n;
  assign total = {hi_digit, Q[2:0]};

  always_ff @(posedge CP or posedge reset) begin
    if (reset) begin
      hi_digit <= 3'd0;
      ovf      <= 1'b0;
      qcc_prev <= 1'b1;
      scan_cnt <= '0;
      sel      <= 1'b0;
      an_n     <= 2'b11;
      seg_n    <= 7'h7F;
`ifdef MOD8_DISPLAY_DIR_EN
      dp_n     <= 1'b1;
`endif
    end else begin
      qcc_prev <= Qcc_n;

      if (wrap) begin
        if (M) begin
          hi_digit <= hi_digit + 3'd1;
          if (hi_digit == 3'd7) ovf <= 1'b1;
        end else begin
          hi_digit <= hi_digit - 3'd1;
          if (hi_digit == 3'd0) ovf <= 1'b1;
        end
      end

      if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        sel      <= ~sel;
      end else begin
        scan_cnt <= scan_cnt + CNT_W'(1);
      end

      an_n  <= sel ? 2'b01 : 2'b10;
      seg_n <= seg_decode(sel ? {1'b0, hi_digit} : Q);
`ifdef MOD8_DISPLAY_DIR_EN
      dp_n  <= sel ? 1'b1 : ~M;
`endif
    end
  end

endmodule

// File: tb/tb_mod8_cascade_display.sv
// Directed self-checking bench for mod8_cascade_display (SCAN_DIV = 4).
`timescale 1ns/1ps
module tb_mod8_cascade_display;

  logic       CP = 1'b0;
  logic       reset;
  logic       M;
  logic [3:0] Q;
  logic       Qcc_n;
  logic [2:0] hi_digit;
  logic [5:0] total;
  logic       ovf;
  logic [1:0] an_n;
  logic [6:0] seg_n;
`ifdef MOD8_DISPLAY_DIR_EN
  logic       dp_n;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  mod8_cascade_display #(.SCAN_DIV(4)) dut (
    .CP(CP), .reset(reset), .M(M), .Q(Q), .Qcc_n(Qcc_n),
    .hi_digit(hi_digit), .total(total), .ovf(ovf), .an_n(an_n), .seg_n(seg_n)
`ifdef MOD8_DISPLAY_DIR_EN
    , .dp_n(dp_n)
`endif
  );

  always #5 CP = ~CP;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic pulse();
    @(negedge CP) Qcc_n = 1'b0;
    @(negedge CP) Qcc_n = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge CP) begin reset = 1'b1; Qcc_n = 1'b1; end
    @(negedge CP) reset = 1'b0;
  endtask

  logic [6:0] seg_tab [16];
  logic       found;

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    reset = 1'b1; M = 1'b1; Q = 4'd3; Qcc_n = 1'b1;
    #2;
    check("rst_hi", 32'(hi_digit), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_an", 32'(an_n), 32'h3);
    check("rst_seg", 32'(seg_n), 32'h7F);
    check("rst_total", 32'(total), 32'd3);

    // Scan: low digit for edges 1..4, high digit from edge 5
    @(negedge CP) reset = 1'b0;
    @(negedge CP);
    check("e1_an", 32'(an_n), 32'h2);
    check("e1_seg", 32'(seg_n), 32'h30);
    repeat (3) @(negedge CP);
    check("e4_an", 32'(an_n), 32'h2);
    @(negedge CP);
    check("e5_an", 32'(an_n), 32'h1);
    check("e5_seg", 32'(seg_n), 32'h40);

    // Up-count eight wraps
    for (int i = 1; i <= 8; i++) begin
      pulse();
      check($sformatf("up_hi%0d", i), 32'(hi_digit), 32'(i % 8));
      if (i == 7) check("up_ovf7", 32'(ovf), 32'd0);
    end
    check("up_ovf8", 32'(ovf), 32'd1);
    check("up_total", 32'(total), 32'd3);

    // Down from reset: underflow to 7
    do_reset();
    M = 1'b0;
    pulse();
    check("dn_hi", 32'(hi_digit), 32'd7);
    check("dn_ovf", 32'(ovf), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CP);
      if (an_n == 2'b01) found = 1'b1;
    end
    check("dn_hi_visible", 32'(found), 32'd1);
    check("dn_seg", 32'(seg_n), 32'h78);

    // Held-low carry counts once
    do_reset();
    M = 1'b1;
    @(negedge CP) Qcc_n = 1'b0;
    repeat (5) @(negedge CP);
    Qcc_n = 1'b1;
    @(negedge CP);
    check("hold_hi", 32'(hi_digit), 32'd1);
    check("hold_ovf", 32'(ovf), 32'd0);

    // Down 1 -> 0 -> 7 -> 6 -> 5
    M = 1'b0;
    repeat (4) pulse();
    check("pre_rst_hi", 32'(hi_digit), 32'd5);
    check("pre_rst_ovf", 32'(ovf), 32'd1);

    // Async reset mid-cycle, with a wrap pending
    @(negedge CP) Qcc_n = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_hi", 32'(hi_digit), 32'd0);
    check("async_ovf", 32'(ovf), 32'd0);
    check("async_an", 32'(an_n), 32'h3);
    check("async_seg", 32'(seg_n), 32'h7F);
    @(negedge CP);
    check("async_hold_hi", 32'(hi_digit), 32'd0);
    check("async_hold_an", 32'(an_n), 32'h3);

    // Out-of-range low digit shows a dash
    Qcc_n = 1'b1; Q = 4'd9; M = 1'b0;
    reset = 1'b0;
    @(negedge CP);
    check("dash_an", 32'(an_n), 32'h2);
    check("dash_seg", 32'(seg_n), 32'h3F);
`ifdef MOD8_DISPLAY_DIR_EN
    check("dp_down", 32'(dp_n), 32'd1);
    M = 1'b1;
    @(negedge CP);
    check("dp_up", 32'(dp_n), 32'd0);
`endif

    // Decode table sweep: edge e shows low digit when ((e-1)/4) is even
    do_reset();
    M = 1'b1;
    for (int k = 0; k < 16; k++) begin
      Q = 4'(k);
      @(negedge CP);
      if (((k / 4) % 2) == 0) begin
        check($sformatf("sw_an%0d", k), 32'(an_n), 32'h2);
        check($sformatf("sw_seg%0d", k), 32'(seg_n), 32'(seg_tab[k]));
      end else begin
        check($sformatf("sw_an%0d", k), 32'(an_n), 32'h1);
        check($sformatf("sw_seg%0d", k), 32'(seg_n), 32'h40);
`ifdef MOD8_DISPLAY_DIR_EN
        check($sformatf("sw_dp%0d", k), 32'(dp_n), 32'd1);
`endif
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
